r5p_bus_arb2: RTL and testbench

- Two-manager to one-subordinate arbiter on the r5p bus protocol (vld/wen/adr/ben/wdt/rdt/rdy).
- Sits directly upstream of the unified memory model. It merges the core's instruction-fetch and load/store buses onto a single memory port, as used on single-port SRAM/FPGA targets.
- Provides round-robin arbitration, grant locking while the subordinate stalls, and per-manager read-data routing with one-cycle read latency.

---
 rtl/r5p_bus_arb2_pkg.sv | 30 +++
 rtl/r5p_arb_rr2.sv | 77 +++++++
 rtl/r5p_bus_arb2.sv | 115 +++++++++++
 tb/tb_r5p_bus_arb2.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/r5p_bus_arb2_pkg.sv
// Shared definitions for the two-manager r5p bus arbiter.
//   - idx_t      : manager index (0 = instruction fetch, 1 = load/store)
//   - r5p_req_t  : request fields at the default bus widths
//   - other_idx  : the opposite manager of a given index
package r5p_bus_arb2_pkg;

    localparam int unsigned R5P_AW  = 32;
    localparam int unsigned R5P_DW  = 32;
    localparam int unsigned R5P_BW  = R5P_DW / 8;
    localparam int unsigned NUM_MGR = 2;

    typedef logic idx_t;

    localparam idx_t IDX_IF = 1'b0;
    localparam idx_t IDX_LS = 1'b1;

    // Request payload at the default widths; blocks with overridden widths
    // declare a local struct of the same shape.
    typedef struct packed {
        logic              wen;
        logic [R5P_AW-1:0] adr;
        logic [R5P_BW-1:0] ben;
        logic [R5P_DW-1:0] wdt;
    } r5p_req_t;

    function automatic idx_t other_idx(input idx_t idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/r5p_arb_rr2.sv
// Two-input round-robin grant with stall lock.
//   clk_i      : system clock
//   rst_i      : synchronous active-high reset
//   vld_i      : request valid per manager
//   rdy_i      : subordinate ready
//   gnt_o      : granted manager index (0 when nobody requests)
//   gnt_vld_o  : granted manager has a valid request
//   hs_o       : handshake of the granted request this cycle
module r5p_arb_rr2
    import r5p_bus_arb2_pkg::*;
#(
    parameter int unsigned PRI = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] vld_i,
    input  logic       rdy_i,
    output idx_t       gnt_o,
    output logic       gnt_vld_o,
    output logic       hs_o
);

    // Reset last grant to the other manager so PRI wins the first conflict.
    localparam idx_t LAST_RST = (PRI == 0) ? IDX_LS : IDX_IF;

    idx_t last_q, last_d;
    logic lock_q, lock_d;
    idx_t owner_q, owner_d;

    idx_t gnt;
    logic gnt_vld;
    logic hs;

    always_comb begin
        gnt = IDX_IF;
        if (lock_q) begin
            gnt = owner_q;
        end else if (vld_i[0] && vld_i[1]) begin
            gnt = other_idx(last_q);
        end else if (vld_i[1]) begin
            gnt = IDX_LS;
        end
        gnt_vld = vld_i[gnt];
        hs      = gnt_vld && rdy_i;
    end

    always_comb begin
        last_d  = last_q;
        lock_d  = lock_q;
        owner_d = owner_q;
        if (hs) begin
            last_d = gnt;
            lock_d = 1'b0;
        end else if (gnt_vld) begin
            // Stalled request: hold the grant until it completes.
            lock_d  = 1'b1;
            owner_d = gnt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q  <= LAST_RST;
            lock_q  <= 1'b0;
            owner_q <= IDX_IF;
        end else begin
            last_q  <= last_d;
            lock_q  <= lock_d;
            owner_q <= owner_d;
        end
    end

    assign gnt_o     = gnt;
    assign gnt_vld_o = gnt_vld;
    assign hs_o      = hs;

endmodule

// File: rtl/r5p_bus_arb2.sv
// Two-manager to one-subordinate r5p bus arbiter.
// Merges instruction fetch (s0) and load/store (s1) onto one memory port (m).
//   clk, rst         : clock, synchronous active-high reset
//   s0_* / s1_*      : manager ports (vld/wen/adr/ben/wdt in, rdt/rdy out)
//   m_*              : subordinate port (vld/wen/adr/ben/wdt out, rdt/rdy in)
// Requests pass through combinationally; read data returns one cycle after
// the read handshake and is held per manager until its next read response.
module r5p_bus_arb2
    import r5p_bus_arb2_pkg::*;
#(
    parameter int unsigned AW  = R5P_AW,
    parameter int unsigned DW  = R5P_DW,
    parameter int unsigned PRI = 1,
    localparam int unsigned BW = DW / 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s0_vld,
    input  logic          s0_wen,
    input  logic [AW-1:0] s0_adr,
    input  logic [BW-1:0] s0_ben,
    input  logic [DW-1:0] s0_wdt,
    output logic [DW-1:0] s0_rdt,
    output logic          s0_rdy,
    input  logic          s1_vld,
    input  logic          s1_wen,
    input  logic [AW-1:0] s1_adr,
    input  logic [BW-1:0] s1_ben,
    input  logic [DW-1:0] s1_wdt,
    output logic [DW-1:0] s1_rdt,
    output logic          s1_rdy,
    output logic          m_vld,
    output logic          m_wen,
    output logic [AW-1:0] m_adr,
    output logic [BW-1:0] m_ben,
    output logic [DW-1:0] m_wdt,
    input  logic [DW-1:0] m_rdt,
    input  logic          m_rdy
);

    if (DW % 8 != 0) begin : g_dw_check
        $error("r5p_bus_arb2: DW must be a multiple of 8");
    end

    typedef struct packed {
        logic          wen;
        logic [AW-1:0] adr;
        logic [BW-1:0] ben;
        logic [DW-1:0] wdt;
    } req_t;

    req_t req0, req1, m_req;
    idx_t gnt;
    logic gnt_vld;
    logic hs;

    logic          rsp_vld_q, rsp_vld_d;
    idx_t          rsp_sel_q, rsp_sel_d;
    logic [DW-1:0] rdt_q [NUM_MGR];
    logic [DW-1:0] rdt_d [NUM_MGR];

    r5p_arb_rr2 #(
        .PRI (PRI)
    ) u_arb (
        .clk_i     (clk),
        .rst_i     (rst),
        .vld_i     ({s1_vld, s0_vld}),
        .rdy_i     (m_rdy),
        .gnt_o     (gnt),
        .gnt_vld_o (gnt_vld),
        .hs_o      (hs)
    );

    always_comb begin
        req0  = '{wen: s0_wen, adr: s0_adr, ben: s0_ben, wdt: s0_wdt};
        req1  = '{wen: s1_wen, adr: s1_adr, ben: s1_ben, wdt: s1_wdt};
        // Idle grant is manager 0, so its fields show on m_* when nobody requests.
        m_req = (gnt == IDX_LS) ? req1 : req0;
    end

    assign m_vld  = gnt_vld;
    assign m_wen  = m_req.wen;
    assign m_adr  = m_req.adr;
    assign m_ben  = m_req.ben;
    assign m_wdt  = m_req.wdt;
    assign s0_rdy = gnt_vld && (gnt == IDX_IF) && m_rdy;
    assign s1_rdy = gnt_vld && (gnt == IDX_LS) && m_rdy;

    always_comb begin
        rsp_vld_d = hs && !m_req.wen;
        rsp_sel_d = hs ? gnt : rsp_sel_q;
        rdt_d     = rdt_q;
        // Capture the response for the manager that issued the previous read.
        if (rsp_vld_q) begin
            rdt_d[rsp_sel_q] = m_rdt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld_q <= 1'b0;
            rsp_sel_q <= IDX_IF;
            rdt_q     <= '{default: '0};
        end else begin
            rsp_vld_q <= rsp_vld_d;
            rsp_sel_q <= rsp_sel_d;
            rdt_q     <= rdt_d;
        end
    end

    // Live response bypasses the holding register in its return cycle.
    assign s0_rdt = (rsp_vld_q && (rsp_sel_q == IDX_IF)) ? m_rdt : rdt_q[0];
    assign s1_rdt = (rsp_vld_q && (rsp_sel_q == IDX_LS)) ? m_rdt : rdt_q[1];

endmodule

// File: tb/tb_r5p_bus_arb2.sv
module tb_r5p_bus_arb2;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned BW  = 4;
    localparam int unsigned PRI = 1;

    logic          clk;
    logic          rst;
    logic          s0_vld, s0_wen, s0_rdy;
    logic [AW-1:0] s0_adr;
    logic [BW-1:0] s0_ben;
    logic [DW-1:0] s0_wdt, s0_rdt;
    logic          s1_vld, s1_wen, s1_rdy;
    logic [AW-1:0] s1_adr;
    logic [BW-1:0] s1_ben;
    logic [DW-1:0] s1_wdt, s1_rdt;
    logic          m_vld, m_wen, m_rdy;
    logic [AW-1:0] m_adr;
    logic [BW-1:0] m_ben;
    logic [DW-1:0] m_wdt, m_rdt;

    r5p_bus_arb2 #(
        .AW  (AW),
        .DW  (DW),
        .PRI (PRI)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .s0_vld (s0_vld),
        .s0_wen (s0_wen),
        .s0_adr (s0_adr),
        .s0_ben (s0_ben),
        .s0_wdt (s0_wdt),
        .s0_rdt (s0_rdt),
        .s0_rdy (s0_rdy),
        .s1_vld (s1_vld),
        .s1_wen (s1_wen),
        .s1_adr (s1_adr),
        .s1_ben (s1_ben),
        .s1_wdt (s1_wdt),
        .s1_rdt (s1_rdt),
        .s1_rdy (s1_rdy),
        .m_vld  (m_vld),
        .m_wen  (m_wen),
        .m_adr  (m_adr),
        .m_ben  (m_ben),
        .m_wdt  (m_wdt),
        .m_rdt  (m_rdt),
        .m_rdy  (m_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [31:0] adr;
        logic [3:0]  ben;
        logic [31:0] wdt;
    } breq_t;

    typedef struct {
        logic        chk;
        logic        chk_rdt;
        logic        m_vld;
        logic        m_wen;
        logic [31:0] m_adr;
        logic [3:0]  m_ben;
        logic [31:0] m_wdt;
        logic        s0_rdy;
        logic        s1_rdy;
        logic [31:0] s0_rdt;
        logic [31:0] s1_rdt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference state: who stalled, who won last, which read is in flight.
    logic [31:0] mem [logic [31:0]];
    logic        lock_on;
    int          lock_own;
    int          last_w;
    logic        rsp_on;
    int          rsp_mgr;
    logic [31:0] rsp_data;
    logic [31:0] held [2];

    breq_t idle_req;

    function automatic breq_t rq(input logic wen, input logic [31:0] adr,
                                 input logic [3:0] ben, input logic [31:0] wdt);
        breq_t r;
        r.wen = wen;
        r.adr = adr;
        r.ben = ben;
        r.wdt = wdt;
        return r;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] adr);
        if (mem.exists(adr)) return mem[adr];
        return adr ^ 32'hC0DE_0000;
    endfunction

    task automatic mem_wr(input breq_t r);
        logic [31:0] w;
        w = mem_rd(r.adr);
        for (int b = 0; b < 4; b++) begin
            if (r.ben[b]) w[8*b +: 8] = r.wdt[8*b +: 8];
        end
        mem[r.adr] = w;
    endtask

    task automatic model_reset();
        lock_on  = 1'b0;
        lock_own = 0;
        last_w   = 1 - PRI;
        rsp_on   = 1'b0;
        rsp_mgr  = 0;
        rsp_data = '0;
        held[0]  = '0;
        held[1]  = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: called just after a posedge, returns just after the next.
    task automatic cycle(input logic rst_in, input logic v0, input breq_t r0,
                         input logic v1, input breq_t r1, input logic rdy,
                         input logic chk_en, output logic acc0, output logic acc1);
        int    w;
        exp_t  e;
        breq_t wr;
        rst    = rst_in;
        s0_vld = v0;
        s0_wen = r0.wen;
        s0_adr = r0.adr;
        s0_ben = r0.ben;
        s0_wdt = r0.wdt;
        s1_vld = v1;
        s1_wen = r1.wen;
        s1_adr = r1.adr;
        s1_ben = r1.ben;
        s1_wdt = r1.wdt;
        m_rdy  = rdy;
        m_rdt  = rsp_on ? rsp_data : $urandom();

        if (lock_on)       w = lock_own;
        else if (v0 && v1) w = 1 - last_w;
        else if (v0)       w = 0;
        else if (v1)       w = 1;
        else               w = -1;

        wr        = (w == 1) ? r1 : r0;
        e.chk     = chk_en;
        e.chk_rdt = chk_en && !rst_in;
        e.m_vld   = (w >= 0);
        e.m_wen   = wr.wen;
        e.m_adr   = wr.adr;
        e.m_ben   = wr.ben;
        e.m_wdt   = wr.wdt;
        e.s0_rdy  = (w == 0) && rdy;
        e.s1_rdy  = (w == 1) && rdy;
        e.s0_rdt  = (rsp_on && rsp_mgr == 0) ? rsp_data : held[0];
        e.s1_rdt  = (rsp_on && rsp_mgr == 1) ? rsp_data : held[1];
        exp_q.push_back(e);

        acc0 = e.s0_rdy;
        acc1 = e.s1_rdy;

        @(posedge clk);
        #1;
        if (rst_in) begin
            model_reset();
        end else begin
            if (rsp_on) held[rsp_mgr] = rsp_data;
            rsp_on = 1'b0;
            if (w >= 0) begin
                if (rdy) begin
                    last_w  = w;
                    lock_on = 1'b0;
                    if (!wr.wen) begin
                        rsp_on   = 1'b1;
                        rsp_mgr  = w;
                        rsp_data = mem_rd(wr.adr);
                    end else begin
                        mem_wr(wr);
                    end
                end else begin
                    lock_on  = 1'b1;
                    lock_own = w;
                end
            end
        end
    endtask

    function automatic breq_t rand_req();
        breq_t r;
        r.wen = ($urandom_range(0, 99) < 30);
        r.adr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        r.ben = 4'($urandom());
        r.wdt = $urandom();
        return r;
    endfunction

    // Monitor: compares DUT outputs mid-cycle against queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    chk("m_vld", 32'(m_vld), 32'(e.m_vld));
                    chk("m_wen", 32'(m_wen), 32'(e.m_wen));
                    chk("m_adr", m_adr, e.m_adr);
                    chk("m_ben", 32'(m_ben), 32'(e.m_ben));
                    chk("m_wdt", m_wdt, e.m_wdt);
                    chk("s0_rdy", 32'(s0_rdy), 32'(e.s0_rdy));
                    chk("s1_rdy", 32'(s1_rdy), 32'(e.s1_rdy));
                    if (e.chk_rdt) begin
                        chk("s0_rdt", s0_rdt, e.s0_rdt);
                        chk("s1_rdt", s1_rdt, e.s1_rdt);
                    end
                end
            end
        end
    end

    initial begin
        logic  a0, a1;
        logic  act [2];
        breq_t cur [2];
        breq_t ra, rb;

        idle_req = rq(1'b0, 32'h0, 4'h0, 32'h0);
        rst    = 1'b1;
        s0_vld = 1'b0; s0_wen = 1'b0; s0_adr = '0; s0_ben = '0; s0_wdt = '0;
        s1_vld = 1'b0; s1_wen = 1'b0; s1_adr = '0; s1_ben = '0; s1_wdt = '0;
        m_rdy  = 1'b0;
        m_rdt  = '0;
        model_reset();
        mem[32'h100] = 32'hDEAD_BEEF;
        mem[32'h000] = 32'h1111_1111;
        mem[32'h004] = 32'h2222_2222;

        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, idle_req, 1'b0, idle_req, 1'b0, 1'b0, a0, a1);
        cycle(1'b1, 1'b0, idle_req, 1'b0, idle_req, 1'b0, 1'b1, a0, a1);
        cycle(1'b0, 1'b0, idle_req, 1'b0, idle_req, 1'b1, 1'b1, a0, a1);

        // Conflict fairness: both request every cycle, grants alternate from PRI.
        ra = rq(1'b0, 32'h20, 4'hF, 32'h0);
        rb = rq(1'b0, 32'h24, 4'hF, 32'h0);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b1, ra, 1'b1, rb, 1'b1, 1'b1, a0, a1);
        cycle(1'b0, 1'b0, idle_req, 1'b0, idle_req, 1'b1, 1'b1, a0, a1);

        // Single manager read with hold afterwards.
        cycle(1'b0, 1'b0, idle_req, 1'b1, rq(1'b0, 32'h100, 4'hF, 32'h0), 1'b1, 1'b1, a0, a1);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, idle_req, 1'b0, idle_req, 1'b1, 1'b1, a0, a1);

        // Stall lock: s0 owns the port while m_rdy is low.
        ra = rq(1'b0, 32'h40, 4'hF, 32'h0);
        rb = rq(1'b0, 32'h44, 4'hF, 32'h0);
        cycle(1'b0, 1'b1, ra, 1'b0, idle_req, 1'b0, 1'b1, a0, a1);
        cycle(1'b0, 1'b1, ra, 1'b1, rb, 1'b0, 1'b1, a0, a1);
        cycle(1'b0, 1'b1, ra, 1'b1, rb, 1'b0, 1'b1, a0, a1);
        cycle(1'b0, 1'b1, ra, 1'b1, rb, 1'b1, 1'b1, a0, a1);
        cycle(1'b0, 1'b0, idle_req, 1'b1, rb, 1'b1, 1'b1, a0, a1);
        cycle(1'b0, 1'b0, idle_req, 1'b0, idle_req, 1'b1, 1'b1, a0, a1);

        // Response routing for consecutive reads from different managers.
        cycle(1'b0, 1'b1, rq(1'b0, 32'h0, 4'hF, 32'h0), 1'b0, idle_req, 1'b1, 1'b1, a0, a1);
        cycle(1'b0, 1'b0, idle_req, 1'b1, rq(1'b0, 32'h4, 4'hF, 32'h0), 1'b1, 1'b1, a0, a1);
        cycle(1'b0, 1'b0, idle_req, 1'b0, idle_req, 1'b1, 1'b1, a0, a1);
        cycle(1'b0, 1'b0, idle_req, 1'b0, idle_req, 1'b1, 1'b1, a0, a1);

        // Write passthrough, no read data change.
        cycle(1'b0, 1'b0, idle_req, 1'b1, rq(1'b1, 32'h8, 4'b0011, 32'hAABB_CCDD),
              1'b1, 1'b1, a0, a1);
        cycle(1'b0, 1'b0, idle_req, 1'b0, idle_req, 1'b1, 1'b1, a0, a1);

        // Reset right after a read handshake drops the pending response.
        cycle(1'b0, 1'b1, rq(1'b0, 32'h100, 4'hF, 32'h0), 1'b0, idle_req, 1'b1, 1'b1, a0, a1);
        cycle(1'b1, 1'b0, idle_req, 1'b0, idle_req, 1'b1, 1'b1, a0, a1);
        cycle(1'b0, 1'b0, idle_req, 1'b0, idle_req, 1'b1, 1'b1, a0, a1);
        cycle(1'b0, 1'b1, ra, 1'b1, rb, 1'b1, 1'b1, a0, a1);
        cycle(1'b0, 1'b0, idle_req, 1'b0, idle_req, 1'b1, 1'b1, a0, a1);

        // Random traffic: managers hold requests until accepted.
        act[0] = 1'b0;
        act[1] = 1'b0;
        cur[0] = idle_req;
        cur[1] = idle_req;
        for (int n = 0; n < 3000; n++) begin
            if (!lock_on && $urandom_range(0, 99) < 2) begin
                act[0] = 1'b0;
                act[1] = 1'b0;
                cycle(1'b1, 1'b0, cur[0], 1'b0, cur[1], 1'($urandom()), 1'b1, a0, a1);
            end else begin
                for (int m = 0; m < 2; m++) begin
                    if (!act[m]) begin
                        act[m] = ($urandom_range(0, 99) < 60);
                        cur[m] = rand_req();
                    end
                end
                cycle(1'b0, act[0], cur[0], act[1], cur[1], ($urandom_range(0, 99) < 70),
                      1'b1, a0, a1);
                if (a0) act[0] = 1'b0;
                if (a1) act[1] = 1'b0;
            end
        end
        cycle(1'b0, 1'b0, idle_req, 1'b0, idle_req, 1'b1, 1'b1, a0, a1);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
